// File: rtl/pipeline_step_ctrl.sv
// Run/single-step controller for the MIPS pipeline.
// Turns the asynchronous change/step debug strobes into a pipeline clock-enable.
// It supports free-run, pause, fixed-length stepping, and a halt on break/trap.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | free-run, pipe_en every cycle
// PAUSE    | pipeline frozen, waiting for a step or a mode toggle
// STEPPING | issuing STEP_CYCLES back-to-back enabled cycles
// HALTED   | frozen by halt_req, only a mode toggle leaves (to PAUSE)
module pipeline_step_ctrl #(
  parameter int STEP_CYCLES = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32,
  parameter int START_STEP  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             change,
  input  logic             step,
  input  logic             halt_req,
  output logic             pipe_en,
  output logic             step_mode,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_PAUSE    = 2'd1;
  localparam logic [1:0] ST_STEPPING = 2'd2;
  localparam logic [1:0] ST_HALTED   = 2'd3;

  localparam logic [1:0] ST_RESET  = (START_STEP != 0) ? ST_PAUSE : ST_RUN;
  localparam logic [7:0] STEP_LOAD = 8'(STEP_CYCLES);

  logic [SYNC_STAGES-1:0] chg_sync;
  logic [SYNC_STAGES-1:0] stp_sync;
  logic                   chg_hist;
  logic                   stp_hist;
  logic                   chg_p;
  logic                   stp_p;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] step_cnt;
  logic [7:0] step_cnt_nxt;
  logic       pend_run;
  logic       pend_run_nxt;
  logic       pend_eff;

  // Synchronize the raw strobes and keep one history flop for edge detection
  always_ff @(posedge clock) begin
    if (!reset) begin
      chg_sync <= '0;
      stp_sync <= '0;
      chg_hist <= 1'b0;
      stp_hist <= 1'b0;
    end else begin
      chg_sync <= {chg_sync[SYNC_STAGES-2:0], change};
      stp_sync <= {stp_sync[SYNC_STAGES-2:0], step};
      chg_hist <= chg_sync[SYNC_STAGES-1];
      stp_hist <= stp_sync[SYNC_STAGES-1];
    end
  end

  assign chg_p = chg_sync[SYNC_STAGES-1] & ~chg_hist;
  assign stp_p = stp_sync[SYNC_STAGES-1] & ~stp_hist;

  // A change arriving on the last step cycle still counts toward the pending toggle
  assign pend_eff = pend_run ^ chg_p;

  // Next-state, step down-counter and pending-run decode
  always_comb begin
    state_nxt    = state;
    step_cnt_nxt = step_cnt;
    pend_run_nxt = pend_run;
    case (state)
      ST_RUN: begin
        if (halt_req)   state_nxt = ST_HALTED;
        else if (chg_p) state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (chg_p) begin
          state_nxt = ST_RUN;
        end else if (stp_p) begin
          state_nxt    = ST_STEPPING;
          step_cnt_nxt = STEP_LOAD;
        end
      end
      ST_STEPPING: begin
        if (halt_req) begin
          state_nxt    = ST_HALTED;
          step_cnt_nxt = 8'd0;
          pend_run_nxt = 1'b0;
        end else if (step_cnt <= 8'd1) begin
          state_nxt    = pend_eff ? ST_RUN : ST_PAUSE;
          step_cnt_nxt = 8'd0;
          pend_run_nxt = 1'b0;
        end else begin
          step_cnt_nxt = step_cnt - 8'd1;
          pend_run_nxt = pend_eff;
        end
      end
      default: begin
        if (chg_p) state_nxt = ST_PAUSE;
      end
    endcase
  end

  // State, step counter and pending-run registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_RESET;
      step_cnt <= 8'd0;
      pend_run <= 1'b0;
    end else begin
      state    <= state_nxt;
      step_cnt <= step_cnt_nxt;
      pend_run <= pend_run_nxt;
    end
  end

  assign pipe_en   = (state == ST_RUN) || (state == ST_STEPPING);
  assign step_mode = (state != ST_RUN);
  assign halted    = (state == ST_HALTED);

  // Count enabled cycles; wraps silently
  always_ff @(posedge clock) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (pipe_en) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Directed bench for pipeline_step_ctrl.
// Instance a is configured as run-after-reset with 3-cycle steps.
// Instance b is configured as pause-after-reset with 4-cycle steps and a 4-bit counter.
module tb_pipeline_step_ctrl;

  logic        clock;
  logic        reset;
  logic        change_a, step_a, halt_req_a;
  logic        pipe_en_a, step_mode_a, halted_a;
  logic [31:0] count_a;
  logic        change_b, step_b, halt_req_b;
  logic        pipe_en_b, step_mode_b, halted_b;
  logic [3:0]  count_b;

  int errors = 0;
  int checks = 0;
  int n, rises, prev;
  logic [31:0] h;

  pipeline_step_ctrl #(.STEP_CYCLES(3), .SYNC_STAGES(2), .CNT_W(32), .START_STEP(0)) dut_a (
    .clock(clock), .reset(reset), .change(change_a), .step(step_a), .halt_req(halt_req_a),
    .pipe_en(pipe_en_a), .step_mode(step_mode_a), .halted(halted_a), .cycle_count(count_a)
  );

  pipeline_step_ctrl #(.STEP_CYCLES(4), .SYNC_STAGES(2), .CNT_W(4), .START_STEP(1)) dut_b (
    .clock(clock), .reset(reset), .change(change_b), .step(step_b), .halt_req(halt_req_b),
    .pipe_en(pipe_en_b), .step_mode(step_mode_b), .halted(halted_b), .cycle_count(count_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    change_a = 1'b0; step_a = 1'b0; halt_req_a = 1'b0;
    change_b = 1'b0; step_b = 1'b0; halt_req_b = 1'b0;
    tick(); tick();
    chk("rst_pipe_en_a",   32'(pipe_en_a),   1);
    chk("rst_step_mode_a", 32'(step_mode_a), 0);
    chk("rst_halted_a",    32'(halted_a),    0);
    chk("rst_count_a",     count_a,          0);
    chk("rst_pipe_en_b",   32'(pipe_en_b),   0);
    chk("rst_step_mode_b", 32'(step_mode_b), 1);

    // free run counts from the first post-reset edge
    reset = 1'b1;
    tick(); chk("run_count_1", count_a, 1);
    tick(); chk("run_count_2", count_a, 2);
    tick(); chk("run_count_3", count_a, 3);

    // change -> PAUSE at E0+2
    change_a = 1'b1;
    tick(); tick();
    chk("pause_latency_en", 32'(pipe_en_a), 1);
    tick();
    chk("pause_en",        32'(pipe_en_a),   0);
    chk("pause_step_mode", 32'(step_mode_a), 1);
    chk("pause_count",     count_a,          6);
    tick(); tick();
    chk("pause_frozen", count_a, 6);

    // held step gives exactly 3 consecutive enabled cycles
    n = 0; rises = 0; prev = 0;
    step_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 10) step_a = 1'b0;
      tick();
      if (pipe_en_a && prev == 0) rises++;
      n += int'(pipe_en_a);
      prev = int'(pipe_en_a);
    end
    chk("step_cycles",    32'(n),           3);
    chk("step_one_burst", 32'(rises),       1);
    chk("step_count",     count_a,          9);
    chk("step_back_pause", 32'(step_mode_a), 1);

    // coincident change and step in PAUSE -> RUN, step dropped
    change_a = 1'b0;
    repeat (4) tick();
    change_a = 1'b1; step_a = 1'b1;
    repeat (3) tick();
    chk("coinc_run_en",   32'(pipe_en_a),   1);
    chk("coinc_run_mode", 32'(step_mode_a), 0);
    repeat (5) tick();
    chk("coinc_stay_run", 32'(step_mode_a), 0);
    change_a = 1'b0; step_a = 1'b0;
    repeat (4) tick();

    // halt in RUN
    halt_req_a = 1'b1;
    tick();
    halt_req_a = 1'b0;
    chk("halt_halted", 32'(halted_a),  1);
    chk("halt_en",     32'(pipe_en_a), 0);
    h = count_a;
    step_a = 1'b1;
    repeat (5) tick();
    chk("halt_step_ignored", 32'(halted_a), 1);
    chk("halt_count_frozen", count_a, h);
    step_a = 1'b0;
    change_a = 1'b1;
    repeat (3) tick();
    chk("halt_to_pause_halted", 32'(halted_a),    0);
    chk("halt_to_pause_mode",   32'(step_mode_a), 1);
    chk("halt_to_pause_en",     32'(pipe_en_a),   0);
    change_a = 1'b0;
    repeat (3) tick();
    n = 0;
    step_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n += int'(pipe_en_a);
    end
    chk("post_halt_step_cycles", 32'(n), 3);
    chk("post_halt_step_count",  count_a, h + 32'd3);
    step_a = 1'b0;
    repeat (3) tick();

    // halt in the middle of a step
    step_a = 1'b1;
    repeat (3) tick();
    chk("mid_step_en", 32'(pipe_en_a), 1);
    halt_req_a = 1'b1;
    tick();
    halt_req_a = 1'b0;
    chk("mid_step_halted", 32'(halted_a),  1);
    chk("mid_step_halt_en", 32'(pipe_en_a), 0);
    step_a = 1'b0;

    // instance b: step, then a 3 ns change glitch across an edge -> RUN after 4 cycles
    step_b = 1'b1;
    tick(); tick();
    chk("b_step_latency", 32'(pipe_en_b), 0);
    tick();
    chk("b_step_start", 32'(pipe_en_b), 1);
    #7 change_b = 1'b1;
    #3 change_b = 1'b0;
    tick(); tick();
    chk("b_still_stepping_mode", 32'(step_mode_b), 1);
    chk("b_still_stepping_en",   32'(pipe_en_b),   1);
    tick();
    chk("b_run_mode",  32'(step_mode_b), 0);
    chk("b_run_en",    32'(pipe_en_b),   1);
    chk("b_run_count", 32'(count_b),     4);
    repeat (13) tick();
    chk("b_count_wrap", 32'(count_b), 1);
    step_b = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
